// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: address width defaults,
// 2-bit saturating counter encodings and default BTB index width.
package branch_predictor_pkg;

    localparam int Addrlen = 32;
    localparam logic [Addrlen-1:0] ZeroWord = '0;

    localparam int IDX_W_DEF = 7;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// Next-state logic of a 2-bit saturating direction counter.
// Ports: ctr (current), taken (resolved direction), ctr_nxt (next value).
module sat_ctr2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        unique case (1'b1)
            taken && (ctr != CTR_ST):   ctr_nxt = ctr + 2'd1;
            !taken && (ctr != CTR_SNT): ctr_nxt = ctr - 2'd1;
            default:                    ctr_nxt = ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters plus branch/mispredict statistics.
// Ports: clk, rst (async active-low), rdy (global stall), query_pc ->
// pred_taken/pred_pc (combinational lookup), branch_* / prediction_res
// (execute-stage resolution), br_cnt/mispred_cnt (wrapping counters).
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ADDR_W = Addrlen,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] query_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_pc,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              branch_taken,
    input  logic              prediction_res,
    output logic [31:0]       br_cnt,
    output logic [31:0]       mispred_cnt
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    logic              valid_q  [DEPTH];
    logic [TAG_W-1:0]  tag_q    [DEPTH];
    logic [ADDR_W-1:0] target_q [DEPTH];
    logic [1:0]        ctr_q    [DEPTH];

    logic [31:0] br_cnt_q;
    logic [31:0] mispred_cnt_q;

    // Lookup path: purely from registered state, so a same-cycle
    // update to the same index is not seen until the next cycle.
    logic [IDX_W-1:0] q_idx;
    logic [TAG_W-1:0] q_tag;
    logic             q_hit;

    assign q_idx = query_pc[IDX_W+1:2];
    assign q_tag = query_pc[ADDR_W-1:IDX_W+2];
    assign q_hit = valid_q[q_idx] && (tag_q[q_idx] == q_tag);

    assign pred_taken = q_hit && ctr_q[q_idx][1];
    assign pred_pc    = pred_taken ? target_q[q_idx]
                                   : query_pc + ADDR_W'(4);

    // Update path
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             upd;
    logic [1:0]       u_ctr_nxt;

    assign u_idx = branch_pc[IDX_W+1:2];
    assign u_tag = branch_pc[ADDR_W-1:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign upd   = rdy && branch_flag;

    // Instruction-alignment bits of the resolved PC carry no index/tag info.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^branch_pc[1:0];

    sat_ctr2 u_sat_ctr2 (
        .ctr     (ctr_q[u_idx]),
        .taken   (branch_taken),
        .ctr_nxt (u_ctr_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_SNT;
            end
        end else if (upd) begin
            if (u_hit) begin
                ctr_q[u_idx] <= u_ctr_nxt;
                if (branch_taken) begin
                    target_q[u_idx] <= branch_target;
                end
            end else if (branch_taken) begin
                // Only a taken miss allocates; not-taken misses never evict.
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= branch_target;
                ctr_q[u_idx]    <= CTR_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q      <= ZeroWord;
            mispred_cnt_q <= ZeroWord;
        end else if (upd) begin
            br_cnt_q <= br_cnt_q + 32'd1;
            if (!prediction_res) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: scoreboarded lookups
// after training sequences, collision, stall, reset and statistics.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] query_pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        branch_flag;
    logic [31:0] branch_pc;
    logic [31:0] branch_target;
    logic        branch_taken;
    logic        prediction_res;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    branch_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .query_pc       (query_pc),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .branch_flag    (branch_flag),
        .branch_pc      (branch_pc),
        .branch_target  (branch_target),
        .branch_taken   (branch_taken),
        .prediction_res (prediction_res),
        .br_cnt         (br_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] npc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_chk;
    int          n_fail;
    logic [31:0] exp_br;
    logic [31:0] exp_mis;

    task automatic push(input logic [31:0] pc, input logic tk,
                        input logic [31:0] npc);
        exp_t x;
        x.pc = pc;
        x.taken = tk;
        x.npc = npc;
        sb.push_back(x);
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk, input logic res);
        @(negedge clk);
        branch_flag = 1'b1;
        branch_pc = pc;
        branch_target = tgt;
        branch_taken = tk;
        prediction_res = res;
        @(posedge clk);
        if (rst && rdy) begin
            exp_br = exp_br + 32'd1;
            if (!res) exp_mis = exp_mis + 32'd1;
        end
        #1;
        branch_flag = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        query_pc = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        push(32'h100, 1'b0, 32'h104);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            query_pc = e.pc;
            #1;
            n_chk++;
            if (pred_taken !== e.taken || pred_pc !== e.npc) begin
                n_fail++;
                $display("FAIL reset_pred pc=%h got %b/%h want %b/%h",
                         e.pc, pred_taken, pred_pc, e.taken, e.npc);
            end
        end
        n_chk++;
        if (br_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnt got %h/%h want 0/0", br_cnt, mispred_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_allocate;
        train(32'h100, 32'h80, 1'b1, 1'b1);
        push(32'h100, 1'b1, 32'h80);
        push(32'h200, 1'b0, 32'h204);
        push(32'hFFFF_FFFC, 1'b0, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            query_pc = e.pc;
            #1;
            n_chk++;
            if (pred_taken !== e.taken || pred_pc !== e.npc) begin
                n_fail++;
                $display("FAIL allocate pc=%h got %b/%h want %b/%h",
                         e.pc, pred_taken, pred_pc, e.taken, e.npc);
            end
        end
        n_chk++;
        if (br_cnt !== 32'd1 || mispred_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL alloc_cnt got %h/%h want 1/0", br_cnt, mispred_cnt);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        branch_flag = 1'b1;
        branch_pc = 32'h180;
        branch_target = 32'h44;
        branch_taken = 1'b1;
        prediction_res = 1'b0;
        query_pc = 32'h100;
        #2;
        rst = 1'b0;
        #1;
        n_chk++;
        if (pred_taken !== 1'b0 || pred_pc !== 32'h104) begin
            n_fail++;
            $display("FAIL async_reset got %b/%h want 0/00000104",
                     pred_taken, pred_pc);
        end
        @(posedge clk);
        @(negedge clk);
        branch_flag = 1'b0;
        rst = 1'b1;
        exp_br = 32'd0;
        exp_mis = 32'd0;
        push(32'h180, 1'b0, 32'h184);
        push(32'h100, 1'b0, 32'h104);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            query_pc = e.pc;
            #1;
            n_chk++;
            if (pred_taken !== e.taken || pred_pc !== e.npc) begin
                n_fail++;
                $display("FAIL reset_mid pc=%h got %b/%h want %b/%h",
                         e.pc, pred_taken, pred_pc, e.taken, e.npc);
            end
        end
        n_chk++;
        if (br_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_cnt got %h/%h want 0/0",
                     br_cnt, mispred_cnt);
        end
    endtask

    task automatic test_hysteresis;
        // alloc(10) NT(01) NT(00) T(01) T(10) T(11) T(11) NT(10)
        logic tk [8] = '{1, 0, 0, 1, 1, 1, 1, 0};
        logic pt [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            train(32'h100, 32'h80, tk[i], 1'b1);
            push(32'h100, pt[i], pt[i] ? 32'h80 : 32'h104);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                query_pc = e.pc;
                #1;
                n_chk++;
                if (pred_taken !== e.taken || pred_pc !== e.npc) begin
                    n_fail++;
                    $display("FAIL hyst step%0d got %b/%h want %b/%h",
                             i, pred_taken, pred_pc, e.taken, e.npc);
                end
            end
        end
    endtask

    task automatic test_alias;
        train(32'h300, 32'h900, 1'b0, 1'b0);
        push(32'h100, 1'b1, 32'h80);
        push(32'h300, 1'b0, 32'h304);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            query_pc = e.pc;
            #1;
            n_chk++;
            if (pred_taken !== e.taken || pred_pc !== e.npc) begin
                n_fail++;
                $display("FAIL alias_nt pc=%h got %b/%h want %b/%h",
                         e.pc, pred_taken, pred_pc, e.taken, e.npc);
            end
        end
        train(32'h300, 32'h40, 1'b1, 1'b0);
        push(32'h100, 1'b0, 32'h104);
        push(32'h300, 1'b1, 32'h40);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            query_pc = e.pc;
            #1;
            n_chk++;
            if (pred_taken !== e.taken || pred_pc !== e.npc) begin
                n_fail++;
                $display("FAIL alias_t pc=%h got %b/%h want %b/%h",
                         e.pc, pred_taken, pred_pc, e.taken, e.npc);
            end
        end
    endtask

    task automatic test_collision;
        @(negedge clk);
        branch_flag = 1'b1;
        branch_pc = 32'h100;
        branch_target = 32'h80;
        branch_taken = 1'b1;
        prediction_res = 1'b0;
        query_pc = 32'h100;
        #1;
        n_chk++;
        if (pred_taken !== 1'b0 || pred_pc !== 32'h104) begin
            n_fail++;
            $display("FAIL collision_pre got %b/%h want 0/00000104",
                     pred_taken, pred_pc);
        end
        @(posedge clk);
        exp_br = exp_br + 32'd1;
        exp_mis = exp_mis + 32'd1;
        #1;
        branch_flag = 1'b0;
        push(32'h100, 1'b1, 32'h80);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            query_pc = e.pc;
            #1;
            n_chk++;
            if (pred_taken !== e.taken || pred_pc !== e.npc) begin
                n_fail++;
                $display("FAIL collision_post pc=%h got %b/%h want %b/%h",
                         e.pc, pred_taken, pred_pc, e.taken, e.npc);
            end
        end
        // Taken hit retargets (JALR-style).
        train(32'h100, 32'hC0, 1'b1, 1'b0);
        push(32'h100, 1'b1, 32'hC0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            query_pc = e.pc;
            #1;
            n_chk++;
            if (pred_taken !== e.taken || pred_pc !== e.npc) begin
                n_fail++;
                $display("FAIL retarget pc=%h got %b/%h want %b/%h",
                         e.pc, pred_taken, pred_pc, e.taken, e.npc);
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] br0;
        logic [31:0] mis0;
        br0 = exp_br;
        mis0 = exp_mis;
        rdy = 1'b0;
        // Three not-taken updates would drop ctr 11 to 00 if not frozen.
        repeat (3) train(32'h100, 32'h200, 1'b0, 1'b0);
        push(32'h100, 1'b1, 32'hC0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            query_pc = e.pc;
            #1;
            n_chk++;
            if (pred_taken !== e.taken || pred_pc !== e.npc) begin
                n_fail++;
                $display("FAIL stall_pred pc=%h got %b/%h want %b/%h",
                         e.pc, pred_taken, pred_pc, e.taken, e.npc);
            end
        end
        n_chk++;
        if (br_cnt !== br0 || mispred_cnt !== mis0) begin
            n_fail++;
            $display("FAIL stall_cnt got %h/%h want %h/%h",
                     br_cnt, mispred_cnt, br0, mis0);
        end
        rdy = 1'b1;
        n_chk++;
        if (br_cnt !== exp_br || mispred_cnt !== exp_mis) begin
            n_fail++;
            $display("FAIL running_cnt got %h/%h want %h/%h",
                     br_cnt, mispred_cnt, exp_br, exp_mis);
        end
    endtask

    task automatic test_stats;
        logic res [5] = '{0, 1, 0, 1, 1};
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_br = 32'd0;
        exp_mis = 32'd0;
        for (int i = 0; i < 5; i++) begin
            train(32'h1000 + 32'(i * 4), 32'h2000, i[0], res[i]);
        end
        n_chk++;
        if (br_cnt !== 32'd5 || mispred_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL stats got %0d/%0d want 5/2", br_cnt, mispred_cnt);
        end
        // Table still trained after the counting run.
        push(32'h1000, 1'b0, 32'h1004);
        push(32'h1004, 1'b1, 32'h2000);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            query_pc = e.pc;
            #1;
            n_chk++;
            if (pred_taken !== e.taken || pred_pc !== e.npc) begin
                n_fail++;
                $display("FAIL stats_tbl pc=%h got %b/%h want %b/%h",
                         e.pc, pred_taken, pred_pc, e.taken, e.npc);
            end
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        force dut.br_cnt_q = 32'hFFFF_FFFF;
        force dut.mispred_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.br_cnt_q;
        release dut.mispred_cnt_q;
        train(32'h100, 32'h80, 1'b0, 1'b0);
        n_chk++;
        if (br_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap got %h/%h want 0/0", br_cnt, mispred_cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        exp_br = 32'd0;
        exp_mis = 32'd0;
        rst = 1'b0;
        rdy = 1'b1;
        query_pc = 32'h0;
        branch_flag = 1'b0;
        branch_pc = 32'h0;
        branch_target = 32'h0;
        branch_taken = 1'b0;
        prediction_res = 1'b1;
        test_reset;
        test_allocate;
        test_reset_mid;
        test_hysteresis;
        test_alias;
        test_collision;
        test_stall;
        test_stats;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
